// File: rtl/rv32v_types_pkg.sv
// Shared types for the vector register-file element sequencer.
package rv32v_types_pkg;

  localparam int unsigned NumLanes = 2;
  localparam int unsigned OffW     = 5;

  typedef enum logic [1:0] {
    SewE8  = 2'd0,
    SewE16 = 2'd1,
    SewE32 = 2'd2,
    SewE64 = 2'd3
  } sew_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } seq_state_t;

  typedef struct packed {
    logic                valid;
    logic [OffW-1:0]     offset;
    logic [NumLanes-1:0] mask;
  } wpipe_entry_t;

endpackage

// File: rtl/rv32v_wb_delay_pipe.sv
// Shift register replaying read chunks as writeback entries after Depth unstalled cycles.
module rv32v_wb_delay_pipe #(
  parameter int unsigned Depth    = 3,
  parameter int unsigned NumLanes = 2,
  parameter int unsigned OffW     = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                shift_en_i,
  input  logic                clear_i,
  input  logic                in_valid_i,
  input  logic [OffW-1:0]     in_offset_i,
  input  logic [NumLanes-1:0] in_mask_i,
  output logic                head_valid_o,
  output logic [OffW-1:0]     head_offset_o,
  output logic [NumLanes-1:0] head_mask_o,
  output logic                pending_o
);

  logic [Depth-1:0]    valid_q;
  logic [OffW-1:0]     offset_q [Depth];
  logic [NumLanes-1:0] mask_q   [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        offset_q[i] <= '0;
        mask_q[i]   <= '0;
      end
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (shift_en_i) begin
      valid_q[0]  <= in_valid_i;
      offset_q[0] <= in_offset_i;
      mask_q[0]   <= in_mask_i;
      for (int i = 1; i < int'(Depth); i++) begin
        valid_q[i]  <= valid_q[i-1];
        offset_q[i] <= offset_q[i-1];
        mask_q[i]   <= mask_q[i-1];
      end
    end
  end

  assign head_valid_o  = valid_q[Depth-1];
  assign head_offset_o = offset_q[Depth-1];
  assign head_mask_o   = mask_q[Depth-1];

  // Entries still travelling behind the head; empty means the head is the last write.
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < int'(Depth) - 1; i++) begin
      pending_o = pending_o | valid_q[i];
    end
  end

endmodule

// File: rtl/rv32v_rf_sequencer.sv
// Steps a vector op through the register-file read port NUM_LANES elements at a time and
// replays each chunk on the writeback port PIPE_DEPTH unstalled cycles later.
module rv32v_rf_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned VL_W       = 6,
  parameter int unsigned OFF_W      = 5,
  parameter int unsigned PIPE_DEPTH = 3
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  logic                 kill,
  input  logic                 stall,
  input  logic [4:0]           vs1_i,
  input  logic [4:0]           vs2_i,
  input  logic [4:0]           vs3_i,
  input  logic [4:0]           vd_i,
  input  logic [VL_W-1:0]      vl_i,
  input  sew_t                 sew_i,
  output logic [4:0]           vs1,
  output logic [4:0]           vs2,
  output logic [4:0]           vs3,
  output logic [OFF_W-1:0]     vs1_offset,
  output logic [OFF_W-1:0]     vs2_offset,
  output logic [OFF_W-1:0]     vs3_offset,
  output sew_t                 sew,
  output sew_t                 eew,
  output logic                 rd_valid,
  output logic [NUM_LANES-1:0] lane_mask,
  output logic [4:0]           vd,
  output logic [OFF_W-1:0]     vd_offset,
  output logic [NUM_LANES-1:0] wen,
  output logic                 busy,
  output logic                 done
);

  // One extra bit so offset + NUM_LANES never wraps against vl = 2**(VL_W-1).
  localparam int unsigned CmpW = (OFF_W + 1 > VL_W) ? OFF_W + 1 : VL_W;

  seq_state_t             state_q, state_d;
  logic [OFF_W-1:0]       offset_q, offset_d;
  logic                   zero_done_q, zero_done_d;
  logic [VL_W-1:0]        vl_q;
  logic [4:0]             vs1_q, vs2_q, vs3_q, vd_q;
  sew_t                   sew_q;

  logic [CmpW-1:0]        off_ext, vl_ext, next_off;
  logic                   last_chunk, capture, pipe_pending, drain_done;
  logic [NUM_LANES-1:0]   chunk_mask;
  logic                   head_valid;
  logic [OFF_W-1:0]       head_offset;
  logic [NUM_LANES-1:0]   head_mask;

  assign off_ext    = CmpW'(offset_q);
  assign vl_ext     = CmpW'(vl_q);
  assign next_off   = off_ext + CmpW'(NUM_LANES);
  assign last_chunk = next_off >= vl_ext;

  always_comb begin
    chunk_mask = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      chunk_mask[i] = (off_ext + CmpW'(i)) < vl_ext;
    end
  end

  assign capture    = (state_q == StIdle) && start && !kill && !stall && (vl_i != '0);
  assign drain_done = (state_q == StDrain) && !stall && !kill && !pipe_pending;

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    zero_done_d = 1'b0;
    if (kill) begin
      state_d  = StIdle;
      offset_d = '0;
    end else if (!stall) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (vl_i != '0) begin
              state_d  = StRun;
              offset_d = '0;
            end else begin
              zero_done_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (last_chunk) begin
            state_d  = StDrain;
            offset_d = '0;
          end else begin
            offset_d = next_off[OFF_W-1:0];
          end
        end
        StDrain: begin
          if (!pipe_pending) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      offset_q    <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      zero_done_q <= zero_done_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vl_q  <= '0;
      vs1_q <= '0;
      vs2_q <= '0;
      vs3_q <= '0;
      vd_q  <= '0;
      sew_q <= SewE8;
    end else if (capture) begin
      vl_q  <= vl_i;
      vs1_q <= vs1_i;
      vs2_q <= vs2_i;
      vs3_q <= vs3_i;
      vd_q  <= vd_i;
      sew_q <= sew_i;
    end
  end

  rv32v_wb_delay_pipe #(
    .Depth    (PIPE_DEPTH),
    .NumLanes (NUM_LANES),
    .OffW     (OFF_W)
  ) u_wb_pipe (
    .clk_i         (CLK),
    .rst_ni        (nRST),
    .shift_en_i    (!stall),
    .clear_i       (kill),
    .in_valid_i    (rd_valid),
    .in_offset_i   (offset_q),
    .in_mask_i     (chunk_mask),
    .head_valid_o  (head_valid),
    .head_offset_o (head_offset),
    .head_mask_o   (head_mask),
    .pending_o     (pipe_pending)
  );

  assign rd_valid   = (state_q == StRun) && !stall;
  assign lane_mask  = rd_valid ? chunk_mask : '0;
  assign vs1        = vs1_q;
  assign vs2        = vs2_q;
  assign vs3        = vs3_q;
  assign vs1_offset = offset_q;
  assign vs2_offset = offset_q;
  assign vs3_offset = offset_q;
  assign sew        = sew_q;
  assign eew        = sew_q;
  assign vd         = vd_q;
  assign vd_offset  = head_offset;
  assign wen        = (head_valid && !stall) ? head_mask : '0;
  assign busy       = state_q != StIdle;
  assign done       = zero_done_q | drain_done;

endmodule
